// File: rtl/pipe_ctrl_if.sv
// Control bundle between the datapath and the pipeline controller: stage stall
// requests and exception info in, stall vector, flush/redirect and perf status out.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] epc_i;
    logic        cnt_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    // Datapath side
    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, epc_i, cnt_clr,
        input  stall, flush, new_pc, stall_cycles, stall_timeout
    );

    // Controller side
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, epc_i, cnt_clr,
        output stall, flush, new_pc, stall_cycles, stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: prioritised stall vector, exception flush/redirect with a
// recovery window, saturating stall-cycle counter and a stuck-stall watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_BASE   = 32'h0000_0020,
    parameter int          REC_CYCLES = 1,
    parameter int          TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;
    localparam logic [3:0]  REC_LOAD  = 4'(REC_CYCLES - 1);
    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_rec_cnt;
    logic [3:0]  w_rec_cnt_next;
    logic [15:0] r_run_cnt;
    logic [15:0] w_run_cnt_next;
    logic [31:0] r_stall_cycles;
    logic        r_stall_timeout;

    logic [3:0]  w_req;
    logic [5:0]  w_stall_req;
    logic [5:0]  w_stall;
    logic        w_flush;
    logic [31:0] w_new_pc;
    logic        w_exc_pending;
    logic        w_stalled;
    logic        w_trip;

    // Request level: 0 = IF, 1 = ID, 2 = EX, 3 = MEM; a request freezes every
    // pipeline register from the PC up to and including its own stage.
    assign w_req = {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stall_bits
            assign w_stall_req[gi + 1] = |w_req[3:gi];
        end
    endgenerate

    assign w_stall_req[0] = w_stall_req[1];
    assign w_stall_req[5] = 1'b0;

    assign w_exc_pending = (bus.excepttype_i != 32'd0);

    always_comb begin
        w_state_next   = r_state;
        w_rec_cnt_next = r_rec_cnt;
        w_flush        = 1'b0;
        w_stall        = w_stall_req;
        w_new_pc       = 32'd0;

        case (r_state)
            ST_RUN, ST_STALL: begin
                if (w_exc_pending) begin
                    // The exception wins over every stall request so the flush lands now.
                    w_flush        = 1'b1;
                    w_stall        = 6'b000000;
                    w_new_pc       = (bus.excepttype_i == ERET_CODE) ? bus.epc_i : EXC_BASE;
                    w_state_next   = ST_RECOVER;
                    w_rec_cnt_next = REC_LOAD;
                end else begin
                    w_state_next = (|w_stall_req) ? ST_STALL : ST_RUN;
                end
            end
            ST_RECOVER: begin
                if (r_rec_cnt == 4'd0) begin
                    w_state_next = (|w_stall_req) ? ST_STALL : ST_RUN;
                end else begin
                    w_rec_cnt_next = r_rec_cnt - 4'd1;
                end
            end
            default: begin
                w_state_next   = ST_RUN;
                w_rec_cnt_next = 4'd0;
            end
        endcase
    end

    assign w_stalled = (|w_stall) && !w_flush;

    // Run counter saturates so a very long stall cannot wrap and re-arm the trip point.
    always_comb begin
        w_run_cnt_next = 16'd0;
        if (w_stalled) begin
            w_run_cnt_next = (r_run_cnt == 16'hFFFF) ? r_run_cnt : r_run_cnt + 16'd1;
        end
    end

    assign w_trip = w_stalled && (({1'b0, r_run_cnt} + 17'd1) >= TIMEOUT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_rec_cnt <= 4'd0;
            r_run_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_next;
            r_rec_cnt <= w_rec_cnt_next;
            r_run_cnt <= w_run_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            r_stall_cycles <= 32'd0;
        end else if (w_stall[0] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_clr) begin
            r_stall_timeout <= 1'b0;
        end else if (w_trip) begin
            r_stall_timeout <= 1'b1;
        end
    end

    assign bus.stall         = w_stall;
    assign bus.flush         = w_flush;
    assign bus.new_pc        = w_new_pc;
    assign bus.stall_cycles  = r_stall_cycles;
    assign bus.stall_timeout = r_stall_timeout;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (short watchdog / long recovery),
// expected outputs queued at drive time and checked mid-cycle.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    pipe_ctrl_if bus_a ();
    pipe_ctrl_if bus_b ();

    pipe_ctrl #(.EXC_BASE(32'h0000_0020), .REC_CYCLES(1), .TIMEOUT(8)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    pipe_ctrl #(.EXC_BASE(32'h0000_0020), .REC_CYCLES(4), .TIMEOUT(1024)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        bit          chk_reg;
        logic [31:0] cycles;
        logic        to;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, expv);
        end
    endtask

    // req = {mem, ex, id, if}
    task automatic step(input bit sel, input logic [3:0] req, input logic [31:0] exc,
                        input logic [31:0] epc, input logic clr, input logic rst_v,
                        input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                        input bit chk, input logic [31:0] e_cyc, input logic e_to,
                        input string tag);
        exp_t  e;
        exp_t  got_e;
        string got_tag;
        logic [5:0]  o_stall;
        logic        o_flush;
        logic [31:0] o_pc;
        logic [31:0] o_cyc;
        logic        o_to;

        @(posedge clk);
        #1;
        if (sel == 1'b0) begin
            {bus_a.stallreq_mem, bus_a.stallreq_ex, bus_a.stallreq_id, bus_a.stallreq_if} = req;
            bus_a.excepttype_i = exc;
            bus_a.epc_i        = epc;
            bus_a.cnt_clr      = clr;
            rst_a              = rst_v;
        end else begin
            {bus_b.stallreq_mem, bus_b.stallreq_ex, bus_b.stallreq_id, bus_b.stallreq_if} = req;
            bus_b.excepttype_i = exc;
            bus_b.epc_i        = epc;
            bus_b.cnt_clr      = clr;
            rst_b              = rst_v;
        end
        e.stall   = e_stall;
        e.flush   = e_flush;
        e.pc      = e_pc;
        e.chk_reg = chk;
        e.cycles  = e_cyc;
        e.to      = e_to;
        exp_q.push_back(e);
        tag_q.push_back(tag);

        @(negedge clk);
        if (sel == 1'b0) begin
            o_stall = bus_a.stall; o_flush = bus_a.flush; o_pc = bus_a.new_pc;
            o_cyc = bus_a.stall_cycles; o_to = bus_a.stall_timeout;
        end else begin
            o_stall = bus_b.stall; o_flush = bus_b.flush; o_pc = bus_b.new_pc;
            o_cyc = bus_b.stall_cycles; o_to = bus_b.stall_timeout;
        end
        got_e   = exp_q.pop_front();
        got_tag = tag_q.pop_front();
        $display("[%0t] %s dut=%s stall=%b flush=%b new_pc=%h cycles=%0d timeout=%b",
                 $time, got_tag, sel ? "B" : "A", o_stall, o_flush, o_pc, o_cyc, o_to);
        check(got_tag, "stall",  32'(o_stall), 32'(got_e.stall));
        check(got_tag, "flush",  32'(o_flush), 32'(got_e.flush));
        check(got_tag, "new_pc", o_pc, got_e.pc);
        if (got_e.chk_reg) begin
            check(got_tag, "stall_cycles",  o_cyc, got_e.cycles);
            check(got_tag, "stall_timeout", 32'(o_to), 32'(got_e.to));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        {bus_a.stallreq_mem, bus_a.stallreq_ex, bus_a.stallreq_id, bus_a.stallreq_if} = 4'b0000;
        {bus_b.stallreq_mem, bus_b.stallreq_ex, bus_b.stallreq_id, bus_b.stallreq_if} = 4'b0000;
        bus_a.excepttype_i = 32'd0; bus_a.epc_i = 32'd0; bus_a.cnt_clr = 1'b0;
        bus_b.excepttype_i = 32'd0; bus_b.epc_i = 32'd0; bus_b.cnt_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(0, 4'b0000, 32'd0, 32'd0, 0, 0, 6'b000000, 0, 32'd0, 1, 32'd0, 0, "reset_idle");

        // ID + MEM together: MEM priority
        step(0, 4'b1010, 32'd0, 32'd0, 0, 0, 6'b011111, 0, 32'd0, 1, 32'd0, 0, "id_mem_c0");
        step(0, 4'b1010, 32'd0, 32'd0, 0, 0, 6'b011111, 0, 32'd0, 1, 32'd1, 0, "id_mem_c1");
        step(0, 4'b1010, 32'd0, 32'd0, 0, 0, 6'b011111, 0, 32'd0, 1, 32'd2, 0, "id_mem_c2");
        step(0, 4'b0000, 32'd0, 32'd0, 0, 0, 6'b000000, 0, 32'd0, 1, 32'd3, 0, "id_mem_after");

        // Single-request encodings
        step(0, 4'b0100, 32'd0, 32'd0, 0, 0, 6'b001111, 0, 32'd0, 1, 32'd3, 0, "ex_only");
        step(0, 4'b0010, 32'd0, 32'd0, 0, 0, 6'b000111, 0, 32'd0, 1, 32'd4, 0, "id_only");
        step(0, 4'b0000, 32'd0, 32'd0, 0, 0, 6'b000000, 0, 32'd0, 1, 32'd5, 0, "idle_1");

        // Exception during EX stall, recovery window of one cycle
        step(0, 4'b0100, 32'h08, 32'd0, 0, 0, 6'b000000, 1, 32'h20, 1, 32'd5, 0, "exc_over_ex");
        step(0, 4'b0000, 32'h08, 32'd0, 0, 0, 6'b000000, 0, 32'd0,  1, 32'd5, 0, "exc_in_recover");
        step(0, 4'b0000, 32'h08, 32'd0, 0, 0, 6'b000000, 1, 32'h20, 1, 32'd5, 0, "exc_after_recover");
        step(0, 4'b0001, 32'h08, 32'd0, 0, 0, 6'b000011, 0, 32'd0,  1, 32'd5, 0, "recover_stall");

        // ERET together with MEM stall: flush wins, redirect to EPC
        step(0, 4'b1000, 32'h0e, 32'h1234, 0, 0, 6'b000000, 1, 32'h1234, 1, 32'd6, 0, "eret_mem");
        step(0, 4'b0000, 32'd0, 32'h1234, 0, 0, 6'b000000, 0, 32'd0, 1, 32'd6, 0, "eret_recover");
        step(0, 4'b0000, 32'd0, 32'd0,    0, 0, 6'b000000, 0, 32'd0, 1, 32'd6, 0, "idle_2");

        // Watchdog with TIMEOUT=8: IF held 10 cycles
        for (int k = 0; k < 10; k++) begin
            step(0, 4'b0001, 32'd0, 32'd0, 0, 0, 6'b000011, 0, 32'd0, 1,
                 32'(6 + k), (k >= 8) ? 1'b1 : 1'b0, $sformatf("wdog_c%0d", k));
        end
        step(0, 4'b0000, 32'd0, 32'd0, 0, 0, 6'b000000, 0, 32'd0, 1, 32'd16, 1, "wdog_drop");
        step(0, 4'b0000, 32'd0, 32'd0, 0, 0, 6'b000000, 0, 32'd0, 1, 32'd16, 1, "wdog_sticky");
        step(0, 4'b0000, 32'd0, 32'd0, 1, 0, 6'b000000, 0, 32'd0, 1, 32'd16, 1, "cnt_clr_pulse");
        step(0, 4'b0001, 32'd0, 32'd0, 1, 0, 6'b000011, 0, 32'd0, 1, 32'd0,  0, "clr_vs_inc");
        step(0, 4'b0000, 32'd0, 32'd0, 0, 0, 6'b000000, 0, 32'd0, 1, 32'd0,  0, "clr_won");

        // Instance B (REC_CYCLES=4): reset inside recovery re-arms exception acceptance
        step(1, 4'b0000, 32'd0,  32'd0, 0, 0, 6'b000000, 0, 32'd0,  1, 32'd0, 0, "b_reset_idle");
        step(1, 4'b0000, 32'h08, 32'd0, 0, 0, 6'b000000, 1, 32'h20, 1, 32'd0, 0, "b_exc");
        step(1, 4'b0010, 32'h08, 32'd0, 0, 0, 6'b000111, 0, 32'd0,  1, 32'd0, 0, "b_recover_1");
        step(1, 4'b0000, 32'h08, 32'd0, 0, 1, 6'b000000, 0, 32'd0,  1, 32'd1, 0, "b_recover_rst");
        step(1, 4'b0000, 32'h08, 32'd0, 0, 0, 6'b000000, 1, 32'h20, 1, 32'd0, 0, "b_exc_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
